// File: rtl/sensor_scan_sequencer.sv
// Autonomous scan sequencer for DataAcquisitionIP_core.
// Walks an 8-entry command table, runs one core measurement per eligible
// slot and queues tagged results in a local FIFO for the CPU to drain.
module sensor_scan_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Start,
  input  logic                         Abort,
  input  logic                         Continuous,
  input  logic [7:0]                   SlotEnable,
  input  logic [255:0]                 SlotCommand,
  output logic [31:0]                  CPUCommand,
  output logic                         STATUS_CLEAR,
  input  logic [31:0]                  ResultForCPU,
  input  logic [2:0]                   StatusBits,
  input  logic                         FifoRdEn,
  output logic [36:0]                  FifoData,
  output logic                         FifoEmpty,
  output logic                         FifoFull,
  output logic [$clog2(FIFO_DEPTH):0]  FifoCount,
  output logic                         Busy,
  output logic                         ScanDone,
  output logic                         Fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CAPTURE   = 3'd4,
    S_CLEAR     = 3'd5,
    S_SETTLE    = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      ptr_r, ptr_s;
  logic            abort_r, abort_s;
  logic [TW-1:0]   tmo_r, tmo_s;
  logic [31:0]     cmd_s;
  logic            scan_done_s;
  logic            push_s;
  logic [36:0]     push_data_s;
  logic [31:0]     slot_cmd_s;
  logic            eligible_s;
  logic            abort_eff_s;

  logic [36:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [CW-1:0]   count_s, count_less_pop_s;
  logic            pop_s;
  logic [36:0]     head_s;

  // A zero command never starts the core, so such a slot is treated as disabled.
  assign slot_cmd_s  = SlotCommand[{ptr_r, 5'd0} +: 32];
  assign eligible_s  = SlotEnable[ptr_r] & (slot_cmd_s != 32'd0);
  // An Abort arriving this cycle acts as if it were already latched.
  assign abort_eff_s = abort_r | Abort;

  // Next-state and datapath decisions for the scan controller.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    abort_s     = abort_r;
    tmo_s       = tmo_r;
    cmd_s       = CPUCommand;
    scan_done_s = 1'b0;
    push_s      = 1'b0;
    push_data_s = 37'd0;
    case (state_r)
      S_IDLE: begin
        abort_s = 1'b0;
        if (Start) begin
          ptr_s   = 3'd0;
          state_s = S_SELECT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SELECT: begin
        if (abort_eff_s) begin
          state_s     = S_IDLE;
          abort_s     = 1'b0;
          scan_done_s = 1'b1;
        end else if (eligible_s) begin
          cmd_s   = slot_cmd_s;
          state_s = S_ISSUE;
        end else if (ptr_r != 3'd7) begin
          ptr_s = ptr_r + 3'd1;
        end else if (Continuous) begin
          ptr_s = 3'd0;
        end else begin
          state_s     = S_IDLE;
          scan_done_s = 1'b1;
        end
      end
      S_ISSUE: begin
        abort_s = abort_eff_s;
        // Busy or done proves the core took the command; drop it so the
        // core cannot restart when it returns to idle.
        if (StatusBits[2] | StatusBits[0]) begin
          cmd_s   = 32'd0;
          tmo_s   = TW'(0);
          state_s = S_WAIT_DONE;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        abort_s = abort_eff_s;
        if (StatusBits[0]) begin
          state_s = S_CAPTURE;
        end else if (tmo_r == TW'(TIMEOUT_CYCLES - 1)) begin
          push_s      = ~FifoFull;
          push_data_s = {1'b1, ptr_r, 1'b0, 32'd0};
          state_s     = S_FAULT;
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      S_CAPTURE: begin
        abort_s = abort_eff_s;
        if (abort_eff_s) begin
          state_s = S_CLEAR;
        end else if (!FifoFull) begin
          push_s      = 1'b1;
          push_data_s = {1'b0, ptr_r, StatusBits[1], ResultForCPU};
          state_s     = S_CLEAR;
        end else begin
          state_s = S_CAPTURE;
        end
      end
      S_CLEAR: begin
        abort_s = abort_eff_s;
        state_s = S_SETTLE;
      end
      S_SETTLE: begin
        abort_s = abort_eff_s;
        if (StatusBits[0]) begin
          state_s = S_SETTLE;
        end else if (abort_eff_s) begin
          state_s     = S_IDLE;
          abort_s     = 1'b0;
          scan_done_s = 1'b1;
        end else if (ptr_r != 3'd7) begin
          ptr_s   = ptr_r + 3'd1;
          state_s = S_SELECT;
        end else if (Continuous) begin
          ptr_s   = 3'd0;
          state_s = S_SELECT;
        end else begin
          state_s     = S_IDLE;
          scan_done_s = 1'b1;
        end
      end
      S_FAULT: begin
        abort_s = 1'b0;
        state_s = S_FAULT;
      end
      default: begin
        state_s = S_IDLE;
        abort_s = 1'b0;
        cmd_s   = 32'd0;
      end
    endcase
  end

  // Controller state and registered control outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r      <= S_IDLE;
      ptr_r        <= 3'd0;
      abort_r      <= 1'b0;
      tmo_r        <= TW'(0);
      CPUCommand   <= 32'd0;
      STATUS_CLEAR <= 1'b0;
      Busy         <= 1'b0;
      ScanDone     <= 1'b0;
      Fault        <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      abort_r      <= abort_s;
      tmo_r        <= tmo_s;
      CPUCommand   <= cmd_s;
      STATUS_CLEAR <= (state_s == S_CLEAR);
      Busy         <= (state_s != S_IDLE) && (state_s != S_FAULT);
      ScanDone     <= scan_done_s;
      Fault        <= (state_s == S_FAULT);
    end
  end

  // Pushes are only issued when not full, so only the pop needs guarding.
  assign pop_s            = FifoRdEn & ~FifoEmpty;
  assign count_less_pop_s = FifoCount - CW'(pop_s);
  assign count_s          = count_less_pop_s + CW'(push_s);
  assign rd_next_s        = rd_ptr_r + AW'(pop_s);

  // Head entry for the next cycle; bypass the write when the FIFO drains to the new entry.
  always_comb begin
    if (count_s == CW'(0)) begin
      head_s = 37'd0;
    end else if (push_s && (count_less_pop_s == CW'(0))) begin
      head_s = push_data_s;
    end else begin
      head_s = mem_r[rd_next_s];
    end
  end

  // Result storage; contents are only visible once the count covers them.
  always_ff @(posedge Clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers, occupancy and registered head/flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      FifoCount <= CW'(0);
      FifoData  <= 37'd0;
      FifoEmpty <= 1'b1;
      FifoFull  <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_ptr_r + AW'(push_s);
      rd_ptr_r  <= rd_next_s;
      FifoCount <= count_s;
      FifoData  <= head_s;
      FifoEmpty <= (count_s == CW'(0));
      FifoFull  <= (count_s == CW'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Self-checking bench for sensor_scan_sequencer with a behavioural core model
// and a queue scoreboard of expected FIFO entries.
module tb_sensor_scan_sequencer;

  logic         Clk = 1'b0;
  logic         Rst, Start, Abort, Continuous, FifoRdEn;
  logic [7:0]   SlotEnable;
  logic [255:0] SlotCommand;
  logic [31:0]  CPUCommand, ResultForCPU;
  logic         STATUS_CLEAR;
  logic [2:0]   StatusBits;
  logic [36:0]  FifoData;
  logic         FifoEmpty, FifoFull, Busy, ScanDone, Fault;
  logic [3:0]   FifoCount;

  int n_vec = 0;
  int n_err = 0;
  int sc_cnt = 0;
  int sd_cnt = 0;
  int c_starts = 0;
  int c_latency;
  bit never_done;
  logic [36:0] sb_q[$];

  // core model state
  int          c_state = 0;
  int          lat_cnt = 0;
  logic [31:0] c_cmd = 32'd0;
  logic        busy_m = 1'b0, err_m = 1'b0, done_m = 1'b0;
  logic [31:0] res_m = 32'd0;

  assign StatusBits   = {busy_m, err_m, done_m};
  assign ResultForCPU = res_m;

  sensor_scan_sequencer #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Continuous(Continuous),
    .SlotEnable(SlotEnable), .SlotCommand(SlotCommand), .CPUCommand(CPUCommand),
    .STATUS_CLEAR(STATUS_CLEAR), .ResultForCPU(ResultForCPU), .StatusBits(StatusBits),
    .FifoRdEn(FifoRdEn), .FifoData(FifoData), .FifoEmpty(FifoEmpty), .FifoFull(FifoFull),
    .FifoCount(FifoCount), .Busy(Busy), .ScanDone(ScanDone), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cmd_of(input int k);
    return 32'h1000_0000 | (32'(k) << 8) | 32'(k & 1);
  endfunction

  function automatic logic [36:0] exp_entry(input int k, input logic [31:0] c);
    return {1'b0, 3'(k), c[0], c ^ 32'h5A34_2001};
  endfunction

  // Core model: IDLE -> BUSY on a non-zero command, COMPLETE after latency, IDLE on STATUS_CLEAR.
  always @(posedge Clk) begin
    if (Rst) begin
      c_state <= 0; busy_m <= 1'b0; done_m <= 1'b0; err_m <= 1'b0; res_m <= 32'd0; lat_cnt <= 0;
    end else begin
      case (c_state)
        0: if (CPUCommand != 32'd0) begin
             c_state <= 1; busy_m <= 1'b1; lat_cnt <= c_latency; c_cmd <= CPUCommand;
             c_starts <= c_starts + 1;
           end
        1: if (!never_done) begin
             if (lat_cnt == 0) begin
               c_state <= 2; busy_m <= 1'b0; done_m <= 1'b1;
               err_m <= c_cmd[0]; res_m <= c_cmd ^ 32'h5A34_2001;
             end else begin
               lat_cnt <= lat_cnt - 1;
             end
           end
        2: if (STATUS_CLEAR) begin
             c_state <= 0; done_m <= 1'b0; err_m <= 1'b0;
           end
        default: c_state <= 0;
      endcase
    end
  end

  // Pulse counters; the command must already be zero when the core is cleared back to idle.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (STATUS_CLEAR) begin
        sc_cnt++;
        check("cmd_at_clear", 64'(CPUCommand), 64'd0);
      end
      if (ScanDone) sd_cnt++;
    end
  end

  task automatic set_cmd(input int k, input logic [31:0] v);
    SlotCommand[k*32 +: 32] = v;
  endtask

  task automatic pulse_start();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
  endtask

  task automatic wait_scan(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (ScanDone) begin ok = 1'b1; break; end
    end
    check(tag, 64'(ok), 64'd1);
    @(negedge Clk);
  endtask

  task automatic drain(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (FifoEmpty) begin FifoRdEn = 1'b0; ok = 1'b1; break; end
      if (sb_q.size() == 0) check({tag, "_extra"}, 64'(FifoData), 64'd0);
      else check(tag, 64'(FifoData), 64'(sb_q.pop_front()));
      FifoRdEn = 1'b1;
    end
    FifoRdEn = 1'b0;
    check({tag, "_drained"}, 64'(ok), 64'd1);
    check({tag, "_left"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc0, sd0, st0, cnt;
    bit ok;
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Continuous = 1'b0; FifoRdEn = 1'b0;
    SlotEnable = 8'd0; SlotCommand = 256'd0; c_latency = 3; never_done = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_cmd", 64'(CPUCommand), 64'd0);
    check("rst_sclr", 64'(STATUS_CLEAR), 64'd0);
    check("rst_empty", 64'(FifoEmpty), 64'd1);
    check("rst_count", 64'(FifoCount), 64'd0);
    check("rst_data", 64'(FifoData), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_fault", 64'(Fault), 64'd0);
    check("rst_done", 64'(ScanDone), 64'd0);
    Rst = 1'b0;

    // single slot 1 measurement
    SlotEnable = 8'b0000_0010;
    set_cmd(1, 32'h4800_0000);
    sb_q.push_back({1'b0, 3'd1, 1'b0, 32'h1234_2001});
    sc0 = sc_cnt; sd0 = sd_cnt;
    pulse_start();
    wait_scan("t1_scandone", 300);
    check("t1_count", 64'(FifoCount), 64'd1);
    check("t1_sclr_pulses", 64'(sc_cnt - sc0), 64'd1);
    check("t1_done_pulses", 64'(sd_cnt - sd0), 64'd1);
    check("t1_busy", 64'(Busy), 64'd0);
    drain("t1_entry", 20);

    // all enabled, slot 3 command zero
    SlotEnable = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      set_cmd(k, (k == 3) ? 32'd0 : cmd_of(k));
      if (k != 3) sb_q.push_back(exp_entry(k, cmd_of(k)));
    end
    st0 = c_starts;
    pulse_start();
    wait_scan("t2_scandone", 800);
    check("t2_starts", 64'(c_starts - st0), 64'd7);
    check("t2_count", 64'(FifoCount), 64'd7);
    drain("t2_entry", 30);

    // abort during WAIT_DONE of slot 2
    SlotEnable = 8'b0000_0111;
    for (int k = 0; k < 3; k++) set_cmd(k, cmd_of(k));
    sb_q.push_back(exp_entry(0, cmd_of(0)));
    sb_q.push_back(exp_entry(1, cmd_of(1)));
    c_latency = 10;
    sc0 = sc_cnt; sd0 = sd_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (CPUCommand == cmd_of(2)) begin ok = 1'b1; break; end
    end
    check("t5_slot2_issued", 64'(ok), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (CPUCommand == 32'd0) begin ok = 1'b1; break; end
    end
    check("t5_slot2_wait", 64'(ok), 64'd1);
    @(negedge Clk); Abort = 1'b1;
    @(negedge Clk); Abort = 1'b0;
    wait_scan("t5_scandone", 200);
    check("t5_sclr_pulses", 64'(sc_cnt - sc0), 64'd3);
    check("t5_done_pulses", 64'(sd_cnt - sd0), 64'd1);
    check("t5_busy", 64'(Busy), 64'd0);
    check("t5_count", 64'(FifoCount), 64'd2);
    drain("t5_entry", 20);

    // continuous scan fills the FIFO and stalls in CAPTURE
    c_latency = 3;
    SlotEnable = 8'hFF;
    Continuous = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_cmd(k, cmd_of(k));
      sb_q.push_back(exp_entry(k, cmd_of(k)));
    end
    sb_q.push_back(exp_entry(0, cmd_of(0)));
    st0 = c_starts;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge Clk);
      if (FifoFull) begin ok = 1'b1; break; end
    end
    check("t3_reach_full", 64'(ok), 64'd1);
    repeat (30) @(negedge Clk);
    check("t3_full", 64'(FifoFull), 64'd1);
    check("t3_busy", 64'(Busy), 64'd1);
    check("t3_core_hold", 64'(StatusBits[0]), 64'd1);
    check("t3_starts", 64'(c_starts - st0), 64'd9);
    @(negedge Clk);
    check("t3_pop_head", 64'(FifoData), 64'(sb_q.pop_front()));
    FifoRdEn = 1'b1;
    @(negedge Clk); FifoRdEn = 1'b0;
    repeat (40) @(negedge Clk);
    check("t3_refull", 64'(FifoCount), 64'd8);
    check("t3_starts2", 64'(c_starts - st0), 64'd10);
    Abort = 1'b1;
    @(negedge Clk); Abort = 1'b0; Continuous = 1'b0;
    wait_scan("t3_scandone", 200);
    check("t3_idle", 64'(Busy), 64'd0);
    drain("t3_entry", 30);

    // reset while in CAPTURE with three entries queued
    SlotEnable = 8'hFF;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if (FifoCount == 4'd3) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < 50 && ok; i++) begin
      if (StatusBits[0] == 1'b0) break;
      @(negedge Clk);
    end
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge Clk);
      if (StatusBits[0] == 1'b1) break;
    end
    check("t6_reach_capture", 64'(ok), 64'd1);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("t6_empty", 64'(FifoEmpty), 64'd1);
    check("t6_count", 64'(FifoCount), 64'd0);
    check("t6_cmd", 64'(CPUCommand), 64'd0);
    check("t6_sclr", 64'(STATUS_CLEAR), 64'd0);
    check("t6_busy", 64'(Busy), 64'd0);
    Rst = 1'b0;
    sb_q.delete();

    // core never finishes: timeout entry and sticky FAULT
    never_done = 1'b1;
    SlotEnable = 8'b0010_0000;
    sb_q.push_back({1'b1, 3'd5, 1'b0, 32'd0});
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (CPUCommand != 32'd0) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < 50 && ok; i++) begin
      @(negedge Clk);
      if (CPUCommand == 32'd0) break;
    end
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      cnt++;
      if (Fault) break;
    end
    check("t4_issued", 64'(ok), 64'd1);
    check("t4_wait_cycles", 64'(cnt), 64'd16);
    check("t4_entry", 64'(FifoData), 64'(sb_q.pop_front()));
    check("t4_count", 64'(FifoCount), 64'd1);
    check("t4_fault", 64'(Fault), 64'd1);
    check("t4_busy", 64'(Busy), 64'd0);
    pulse_start();
    repeat (5) @(negedge Clk);
    check("t4_fault_hold", 64'(Fault), 64'd1);
    check("t4_start_ignored", 64'(Busy), 64'd0);
    check("t4_cmd_idle", 64'(CPUCommand), 64'd0);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    never_done = 1'b0;
    @(negedge Clk);
    check("t4_fault_cleared", 64'(Fault), 64'd0);
    check("t4_empty", 64'(FifoEmpty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
